idli_ctrl_seq_m: RTL and testbench
==================================

Name: idli_ctrl_seq_m

Overview:
- Parametrised sequencing controller for the nibble-serial idli core.
- Keeps the slice counter that splits each word into 2**CTR_W slices, one per cycle.
- Runs the SQI fetch preamble (redirect, command, address, dummy) before decode is enabled, each phase with a configurable word length.
- Also adds stall and mid-run redirect (branch/exception refetch).

Parameters:
- CTR_W, 2, slice counter width; one word = 2**CTR_W cycles (legal 1..4).
- CMD_WORDS, 1, words spent in CMD phase (legal 1..7).
- ADDR_WORDS, 1, words spent in ADDR phase (legal 1..7).
- DUMMY_WORDS, 1, words spent in DUMMY phase (legal 0..7; 0 = phase skipped).

Ports:
- i_ctrl_gck  in  1  gated core clock, rising edge.
- i_ctrl_rst_n  in  1  reset, asynchronous, active-low.
- i_ctrl_stall  in  1  freeze slice counter, word counter and state this cycle.
- i_ctrl_redirect  in  1  request refetch; may pulse on any cycle.
- o_ctrl_ctr  out  CTR_W  current slice index.
- o_ctrl_ctr_first_cycle  out  1  ctr == 0.
- o_ctrl_ctr_last_cycle  out  1  ctr == all-ones.
- o_ctrl_sqi_redirect  out  1  state == REDIRECT.
- o_ctrl_phase  out  3  0 REDIRECT, 1 CMD, 2 ADDR, 3 DUMMY, 4 RUN.
- o_ctrl_dcd_enc_vld  out  1  state == RUN.
- o_ctrl_redirect_pend  out  1  redirect latched, not yet taken.

Behaviour:
- Reset (async, any time, including mid-word): ctr=0, state=REDIRECT, word_ctr=0, pend=0.
  - Outputs at reset: first=1, last=0, sqi_redirect=1, phase=0, dcd_enc_vld=0, redirect_pend=0.
  - On deassertion the sequence restarts cleanly from slice 0.
- Slice counter:
  - ctr_d = ctr_q + 1 modulo 2**CTR_W when i_ctrl_stall=0; holds when stalled.
  - Wraps all-ones -> 0 with no extra cycle.
  - last/first are combinational from ctr_q and remain asserted while stalled.
- Word boundary ("adv") = o_ctrl_ctr_last_cycle & ~i_ctrl_stall. State and word_ctr update only on adv.
- Word counter:
  - Width 3; counts words completed within the current phase.
  - Cleared on every phase change; incremented on adv otherwise.
- State transitions on adv, first matching rule wins:
  1. pend=1, or i_ctrl_redirect=1 this cycle -> REDIRECT (from any state, including REDIRECT itself, which then restarts its word).
  2. REDIRECT -> CMD.
  3. CMD -> ADDR when word_ctr == CMD_WORDS-1.
  4. ADDR -> DUMMY when word_ctr == ADDR_WORDS-1, or -> RUN directly if DUMMY_WORDS == 0.
  5. DUMMY -> RUN when word_ctr == DUMMY_WORDS-1.
  6. RUN -> RUN.
- REDIRECT always lasts exactly one word.
- Redirect pending flag:
  - Set when i_ctrl_redirect=1 on a cycle that is not adv, including while stalled on the last slice.
  - Cleared on adv; entering REDIRECT consumes it.
  - Set and clear in the same cycle: clear wins, because the transition already honours the request.
  - Multiple pulses within one word collapse into a single redirect.
- o_ctrl_dcd_enc_vld drops in the first cycle of the REDIRECT word. No decode-valid cycle is issued between the request word's end and the next RUN entry.
- Latency with defaults, no stall: dcd_enc_vld rises (2 + CMD_WORDS + ADDR_WORDS + DUMMY_WORDS - 1) words = 16 cycles after reset release.
- Stall during REDIRECT/preamble extends the phase cycle-for-cycle; o_ctrl_sqi_redirect stays high.
- No X on outputs for any legal parameter set. Illegal parameters are flagged by an elaboration-time check.

Test Plan:
- Defaults, reset release, no stall/redirect -> phase 0,1,2,3 for 4 cycles each; dcd_enc_vld=1 from cycle 16; ctr cycles 0..3; last high on ctr=3 only.
- Defaults, stall high for 3 cycles at ctr=3 in ADDR -> ctr holds 3, last stays 1, phase stays 2; DUMMY entered on first unstalled cycle; RUN delayed to cycle 19.
- In RUN, i_ctrl_redirect pulse at ctr=1 -> redirect_pend=1 at ctr=2,3; phase=0 and sqi_redirect=1 at next ctr=0; pend=0; RUN re-entered 16 cycles later.
- Redirect pulse at ctr=3 (no stall) during ADDR -> direct REDIRECT next cycle; pend never asserts; CMD follows one word later.
- CTR_W=3, CMD=1, ADDR=3, DUMMY=0 -> ctr wraps 7->0; phase sequence 0(8),1(8),2(24),4; dcd_enc_vld at cycle 40.
- Async reset asserted mid-word in DUMMY at ctr=2 -> immediately ctr=0, phase=0, pend=0, dcd_enc_vld=0; the full preamble replays after release.

Source files
------------

// File: rtl/idli_ctrl_seq_m.sv
// Sequencing controller for the nibble-serial idli core: slice counter, SQI fetch
// preamble (redirect/cmd/addr/dummy), stall and mid-run refetch handling.
module idli_ctrl_seq_m #(
    parameter int CTR_W       = 2,
    parameter int CMD_WORDS   = 1,
    parameter int ADDR_WORDS  = 1,
    parameter int DUMMY_WORDS = 1
) (
    input  logic             i_ctrl_gck,
    input  logic             i_ctrl_rst_n,
    input  logic             i_ctrl_stall,
    input  logic             i_ctrl_redirect,
    output logic [CTR_W-1:0] o_ctrl_ctr,
    output logic             o_ctrl_ctr_first_cycle,
    output logic             o_ctrl_ctr_last_cycle,
    output logic             o_ctrl_sqi_redirect,
    output logic [2:0]       o_ctrl_phase,
    output logic             o_ctrl_dcd_enc_vld,
    output logic             o_ctrl_redirect_pend
);

    if (CTR_W < 1 || CTR_W > 4 || CMD_WORDS < 1 || CMD_WORDS > 7 ||
        ADDR_WORDS < 1 || ADDR_WORDS > 7 || DUMMY_WORDS < 0 || DUMMY_WORDS > 7) begin : g_param_err
        $error("idli_ctrl_seq_m: illegal parameter set");
    end

    // Encodings double as the externally visible phase number.
    typedef enum logic [2:0] {
        ST_REDIRECT = 3'd0,
        ST_CMD      = 3'd1,
        ST_ADDR     = 3'd2,
        ST_DUMMY    = 3'd3,
        ST_RUN      = 3'd4
    } state_t;

    localparam logic [2:0] CMD_LAST   = 3'(CMD_WORDS - 1);
    localparam logic [2:0] ADDR_LAST  = 3'(ADDR_WORDS - 1);
    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_WORDS - 1);

    logic [CTR_W-1:0] ctr_q, ctr_d;
    state_t           state_q, state_d;
    logic [2:0]       word_q, word_d;
    logic             pend_q, pend_d;
    logic             last;
    logic             adv;
    logic             take_redirect;

    assign last          = &ctr_q;
    assign adv           = last & ~i_ctrl_stall;
    assign take_redirect = pend_q | i_ctrl_redirect;

    always_ff @(posedge i_ctrl_gck or negedge i_ctrl_rst_n) begin
        if (!i_ctrl_rst_n) begin
            ctr_q   <= '0;
            state_q <= ST_REDIRECT;
            word_q  <= 3'd0;
            pend_q  <= 1'b0;
        end else begin
            ctr_q   <= ctr_d;
            state_q <= state_d;
            word_q  <= word_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        ctr_d   = i_ctrl_stall ? ctr_q : ctr_q + CTR_W'(1);
        state_d = state_q;
        word_d  = word_q;
        pend_d  = pend_q;
        if (adv) begin
            // The word boundary itself honours any request, so the flag always clears here.
            pend_d = 1'b0;
            if (take_redirect) begin
                state_d = ST_REDIRECT;
            end else begin
                unique case (state_q)
                    ST_REDIRECT: state_d = ST_CMD;
                    ST_CMD:      if (word_q == CMD_LAST) state_d = ST_ADDR;
                    ST_ADDR:     if (word_q == ADDR_LAST)
                                     state_d = (DUMMY_WORDS == 0) ? ST_RUN : ST_DUMMY;
                    ST_DUMMY:    if (word_q == DUMMY_LAST) state_d = ST_RUN;
                    ST_RUN:      state_d = ST_RUN;
                    default:     state_d = ST_REDIRECT;
                endcase
            end
            word_d = (take_redirect || state_d != state_q) ? 3'd0 : word_q + 3'd1;
        end else if (i_ctrl_redirect) begin
            pend_d = 1'b1;
        end
    end

    assign o_ctrl_ctr             = ctr_q;
    assign o_ctrl_ctr_first_cycle = (ctr_q == '0);
    assign o_ctrl_ctr_last_cycle  = last;
    assign o_ctrl_sqi_redirect    = (state_q == ST_REDIRECT);
    assign o_ctrl_phase           = state_q;
    assign o_ctrl_dcd_enc_vld     = (state_q == ST_RUN);
    assign o_ctrl_redirect_pend   = pend_q;

endmodule

// File: tb/tb_idli_ctrl_seq_m.sv
// Randomized bench for idli_ctrl_seq_m: two parameter sets driven in parallel and
// compared every cycle against a word-count reference model.
module tb_idli_ctrl_seq_m;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic rd = 1'b0;

    logic [1:0] a_ctr;
    logic       a_first, a_last, a_sqi, a_vld, a_pend;
    logic [2:0] a_phase;
    logic [2:0] b_ctr;
    logic       b_first, b_last, b_sqi, b_vld, b_pend;
    logic [2:0] b_phase;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    idli_ctrl_seq_m u_dut_a (
        .i_ctrl_gck(clk), .i_ctrl_rst_n(rst_n), .i_ctrl_stall(stall), .i_ctrl_redirect(rd),
        .o_ctrl_ctr(a_ctr), .o_ctrl_ctr_first_cycle(a_first), .o_ctrl_ctr_last_cycle(a_last),
        .o_ctrl_sqi_redirect(a_sqi), .o_ctrl_phase(a_phase), .o_ctrl_dcd_enc_vld(a_vld),
        .o_ctrl_redirect_pend(a_pend)
    );

    idli_ctrl_seq_m #(.CTR_W(3), .CMD_WORDS(1), .ADDR_WORDS(3), .DUMMY_WORDS(0)) u_dut_b (
        .i_ctrl_gck(clk), .i_ctrl_rst_n(rst_n), .i_ctrl_stall(stall), .i_ctrl_redirect(rd),
        .o_ctrl_ctr(b_ctr), .o_ctrl_ctr_first_cycle(b_first), .o_ctrl_ctr_last_cycle(b_last),
        .o_ctrl_sqi_redirect(b_sqi), .o_ctrl_phase(b_phase), .o_ctrl_dcd_enc_vld(b_vld),
        .o_ctrl_redirect_pend(b_pend)
    );

    // Reference: a word index since the last refetch start; the phase is read off
    // cumulative word counts of the preamble.
    int p_w[2] = '{2, 3};
    int p_c[2] = '{1, 1};
    int p_a[2] = '{1, 3};
    int p_d[2] = '{1, 0};
    int m_sl[2];
    int m_w[2];
    bit m_rq[2];
    int lat[2] = '{-1, -1};

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int phase_of(input int i, input int w);
        if (w == 0) return 0;
        if (w < 1 + p_c[i]) return 1;
        if (w < 1 + p_c[i] + p_a[i]) return 2;
        if (w < 1 + p_c[i] + p_a[i] + p_d[i]) return 3;
        return 4;
    endfunction

    task automatic model_reset(input int i);
        m_sl[i] = 0;
        m_w[i]  = 0;
        m_rq[i] = 1'b0;
    endtask

    task automatic model_step(input int i);
        int n;
        n = 1 << p_w[i];
        if (m_sl[i] == n - 1 && !stall) begin
            if (m_rq[i] || rd) m_w[i] = 0;
            else if (m_w[i] < 1 + p_c[i] + p_a[i] + p_d[i]) m_w[i]++;
            m_rq[i] = 1'b0;
        end else if (rd) begin
            m_rq[i] = 1'b1;
        end
        if (!stall) m_sl[i] = (m_sl[i] + 1) % n;
    endtask

    task automatic check_dut(input int i, input int ctr, input bit first, input bit last,
                             input bit sqi, input int phase, input bit vld, input bit pend);
        int ph;
        ph = phase_of(i, m_w[i]);
        chk(i == 0 ? "a_ctr" : "b_ctr", ctr, m_sl[i]);
        chk(i == 0 ? "a_first" : "b_first", int'(first), int'(m_sl[i] == 0));
        chk(i == 0 ? "a_last" : "b_last", int'(last), int'(m_sl[i] == (1 << p_w[i]) - 1));
        chk(i == 0 ? "a_phase" : "b_phase", phase, ph);
        chk(i == 0 ? "a_sqi" : "b_sqi", int'(sqi), int'(ph == 0));
        chk(i == 0 ? "a_vld" : "b_vld", int'(vld), int'(ph == 4));
        chk(i == 0 ? "a_pend" : "b_pend", int'(pend), int'(m_rq[i]));
    endtask

    // Asserts reset away from the clock edge and checks the immediate async effect.
    task automatic do_reset();
        stall = 1'b0;
        rd    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_a_ctr", int'(a_ctr), 0);
        chk("rst_a_first", int'(a_first), 1);
        chk("rst_a_last", int'(a_last), 0);
        chk("rst_a_sqi", int'(a_sqi), 1);
        chk("rst_a_phase", int'(a_phase), 0);
        chk("rst_a_vld", int'(a_vld), 0);
        chk("rst_a_pend", int'(a_pend), 0);
        chk("rst_b_ctr", int'(b_ctr), 0);
        chk("rst_b_phase", int'(b_phase), 0);
        chk("rst_b_vld", int'(b_vld), 0);
        model_reset(0);
        model_reset(1);
    endtask

    initial begin
        int cyc;
        int stage;
        int mode;
        model_reset(0);
        model_reset(1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc   = 0;
        stage = 0;
        for (int n = 0; n < 8000; n++) begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset(0);
                model_reset(1);
            end else begin
                model_step(0);
                model_step(1);
                cyc++;
            end
            #1;
            check_dut(0, int'(a_ctr), a_first, a_last, a_sqi, int'(a_phase), a_vld, a_pend);
            check_dut(1, int'(b_ctr), b_first, b_last, b_sqi, int'(b_phase), b_vld, b_pend);
            if (stage == 0 && rst_n) begin
                if (a_vld && lat[0] < 0) lat[0] = cyc;
                if (b_vld && lat[1] < 0) lat[1] = cyc;
            end

            if (!rst_n) begin
                rst_n = 1'b1;
                cyc   = 0;
            end else if (stage == 0) begin
                stall = 1'b0;
                rd    = 1'b0;
                if (cyc == 60) begin
                    chk("lat_default", lat[0], 16);
                    chk("lat_w3_nodummy", lat[1], 40);
                    do_reset();
                    stage = 1;
                end
            end else if (stage == 1) begin
                if (cyc == 14) begin
                    chk("pre_rst_phase", int'(a_phase), 3);
                    chk("pre_rst_ctr", int'(a_ctr), 2);
                    do_reset();
                    stage = 2;
                end
            end else begin
                mode  = (n / 200) % 3;
                stall = (mode == 0) ? ($urandom_range(5) == 0) :
                        (mode == 1) ? ($urandom_range(3) == 0) : ($urandom_range(2) == 0);
                rd    = (mode == 0) ? 1'b0 :
                        (mode == 1) ? ($urandom_range(39) == 0) : ($urandom_range(7) == 0);
                if ($urandom_range(399) == 0) do_reset();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
